// File: rtl/nibble_serial_adder_32_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_32_if
//  Description : Request/response bundle for the nibble-serial adder.
//                The master issues operands with start; the slave answers
//                with busy, a one-cycle done pulse and the result flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] inp0;
    logic [WIDTH-1:0] inp1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, cin, inp0, inp1,
        input  busy, done, result, carry, overflow, zero
    );

    modport slave (
        input  start, sub, cin, inp0, inp1,
        output busy, done, result, carry, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_32.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_32 (with full_adder_four_bit slice)
//  Description : WIDTH-bit add/subtract built from a single 4-bit adder
//                slice reused once per nibble, LSB nibble first. Returns
//                result, carry, signed overflow and zero with a
//                start/busy/done handshake; latency is WIDTH/4 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================

// Combinational 4-bit adder slice: {carry, sum} = inp0 + inp1 + cin.
module full_adder_four_bit (
    input  logic [3:0] inp0,
    input  logic [3:0] inp1,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [4:0] w_total;

    assign w_total = {1'b0, inp0} + {1'b0, inp1} + {4'b0000, cin};
    assign sum     = w_total[3:0];
    assign carry   = w_total[4];
endmodule

module nibble_serial_adder_32 #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_adder_32_if.slave bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [CNT_W-1:0] c_last_nib = CNT_W'(NIB - 1);
    localparam logic [0:0]       c_idle     = 1'b0;
    localparam logic [0:0]       c_run      = 1'b1;

    // Operand widths that do not split into at least two whole nibbles
    // cannot be handled by the serial schedule.
    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
            $error("nibble_serial_adder_32: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    logic             w_accept;
    logic             w_last;
    logic [CNT_W+1:0] w_bit_base;
    logic [3:0]       w_slice_a;
    logic [3:0]       w_slice_b;
    logic [3:0]       w_slice_sum;
    logic             w_slice_carry;

    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    // A new request is only taken while idle; anything else is dropped.
    assign w_accept   = (r_state == c_idle) && bus.start;
    assign w_last     = (r_state == c_run) && (r_cnt == c_last_nib);
    assign w_bit_base = {r_cnt, 2'b00};
    assign w_slice_a  = r_a[w_bit_base +: 4];
    assign w_slice_b  = r_b[w_bit_base +: 4];

    full_adder_four_bit u_slice (
        .inp0  (w_slice_a),
        .inp1  (w_slice_b),
        .cin   (r_c),
        .sum   (w_slice_sum),
        .carry (w_slice_carry)
    );

    // Accumulator as it will look after the current nibble lands; on the
    // final nibble this is the full-width result.
    always_comb begin
        w_acc_next                  = r_acc;
        w_acc_next[w_bit_base +: 4] = w_slice_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on an accepted start, RUN -> IDLE after
    // the top nibble.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_state_next = c_run;
                end
            end
            c_run: begin
                if (w_last) begin
                    w_state_next = c_idle;
                end
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    // Operand capture, nibble counter, inter-nibble carry and accumulator.
    // Subtract is folded into the operands as A + ~B + 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_a   <= bus.inp0;
            r_b   <= bus.sub ? ~bus.inp1 : bus.inp1;
            r_c   <= bus.sub ? 1'b1 : bus.cin;
            r_cnt <= '0;
        end else if (r_state == c_run) begin
            r_acc <= w_acc_next;
            r_c   <= w_slice_carry;
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Visible outputs change only on the completion edge so a consumer can
    // keep reading the previous result throughout the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_result   <= w_acc_next;
                r_carry    <= w_slice_carry;
                r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                              (w_slice_sum[3] != r_a[WIDTH-1]);
                r_zero     <= (w_acc_next == '0);
            end
        end
    end

    assign bus.busy     = (r_state == c_run);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder_32
//  Description : Directed table of add/subtract vectors with hand-computed
//                results, plus sequences for busy protection, back-to-back
//                restart and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_32;
    localparam int WIDTH = 32;
    localparam int LAT   = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    nibble_serial_adder_32_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_32 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs[10];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"},     32'(bus.busy),     32'd0);
        check({tag, " done"},     32'(bus.done),     32'd0);
        check({tag, " result"},   bus.result,        32'd0);
        check({tag, " carry"},    32'(bus.carry),    32'd0);
        check({tag, " overflow"}, 32'(bus.overflow), 32'd0);
        check({tag, " zero"},     32'(bus.zero),     32'd0);
    endtask

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic c);
        bus.start = 1'b1;
        bus.inp0  = a;
        bus.inp1  = b;
        bus.sub   = s;
        bus.cin   = c;
    endtask

    // Called at the negedge where start was just driven; returns at the
    // negedge where done is seen (or after the cycle budget runs out).
    task automatic finish_op(input string tag, input logic [31:0] exp_res,
                             input logic exp_c, input logic exp_v, input logic exp_z);
        logic [31:0] prev_res;
        logic        held;
        bit          seen;
        int          cycles;
        int          busy_cycles;
        prev_res    = bus.result;
        held        = 1'b1;
        seen        = 1'b0;
        cycles      = 0;
        busy_cycles = 0;
        while ((cycles < 20) && !seen) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                // Operands are latched; disturb them to prove it.
                bus.start = 1'b0;
                bus.inp0  = ~bus.inp0;
                bus.inp1  = ~bus.inp1;
                bus.sub   = ~bus.sub;
                bus.cin   = ~bus.cin;
            end
            if (bus.busy) begin
                busy_cycles++;
                if (bus.result !== prev_res) held = 1'b0;
            end
            if (bus.done) seen = 1'b1;
        end
        check({tag, " done seen"},   32'(seen),        32'd1);
        check({tag, " latency"},     cycles - 1,       LAT);
        check({tag, " busy cycles"}, busy_cycles,      LAT);
        check({tag, " result held"}, 32'(held),        32'd1);
        check({tag, " result"},      bus.result,       exp_res);
        check({tag, " carry"},       32'(bus.carry),   32'(exp_c));
        check({tag, " overflow"},    32'(bus.overflow), 32'(exp_v));
        check({tag, " zero"},        32'(bus.zero),    32'(exp_z));
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
        check({tag, " busy after"},     32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          done_cnt;
        int          busy_seen;
        logic [31:0] prev_res;
        logic [31:0] done_res;
        logic        held;

        //          a             b             sub   cin   res           c     v     z
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000000F, 32'h00000000, 1'b0, 1'b1, 32'h00000010, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h89ABCDEF, 32'h89ABCDEF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.inp0  = '0;
        bus.inp1  = '0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("post-release");

        for (int i = 0; i < 10; i++) begin
            drive_start(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            finish_op($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z);
            check_idle_after($sformatf("vec%0d", i));
        end

        // Busy protection: a start pulse during RUN is ignored.
        prev_res  = bus.result;
        held      = 1'b1;
        done_cnt  = 0;
        done_res  = '0;
        drive_start(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 3) drive_start(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
            if (k == 4) bus.start = 1'b0;
            if (bus.busy && (bus.result !== prev_res)) held = 1'b0;
            if (bus.done) begin
                done_cnt++;
                done_res = bus.result;
            end
        end
        check("busyprot done count",  done_cnt,      32'd1);
        check("busyprot result",      done_res,      32'h23456789);
        check("busyprot result held", 32'(held),     32'd1);
        check("busyprot idle at end", 32'(bus.busy), 32'd0);

        // Back-to-back: restart in the done cycle.
        drive_start(32'h00000100, 32'h00000200, 1'b0, 1'b0);
        finish_op("b2b first", 32'h00000300, 1'b0, 1'b0, 1'b0);
        drive_start(32'd10, 32'd20, 1'b0, 1'b0);
        finish_op("b2b second", 32'd30, 1'b0, 1'b0, 1'b0);
        check_idle_after("b2b");

        // Reset in the middle of an operation.
        drive_start(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        done_cnt  = 0;
        busy_seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (bus.busy) busy_seen++;
        end
        check("midreset no done", done_cnt,  32'd0);
        check("midreset no busy", busy_seen, 32'd0);
        drive_start(32'd1, 32'd1, 1'b0, 1'b0);
        finish_op("after reset", 32'd2, 1'b0, 1'b0, 1'b0);
        check_idle_after("after reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
